// File: rtl/config_loader.sv
// ============================================================================
// Module   : config_loader
// Purpose  : Unpacks a word stream LSB-first onto the fabric's serial config
//            chain, generating config_clk as a divided strobe of clk.
//            Optional trailing CRC-16-CCITT check when CFG_CRC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module config_loader #(
    parameter int CONFIG_WIDTH = 4651,
    parameter int WORD_W       = 32,
    parameter int CLK_DIV      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [WORD_W-1:0] i_word_data,
    input  logic              i_word_valid,
    output logic              o_word_ready,
    output logic              o_config_in,
    output logic              o_config_clk,
    output logic              o_config_en,
    input  logic              i_config_out,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_crc_err
);

    localparam int CNT_W  = $clog2(CONFIG_WIDTH + 1);
    localparam int WBIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_SHIFT_LO  = 3'd2;
    localparam logic [2:0] S_SHIFT_HI  = 3'd3;
    localparam logic [2:0] S_FINISH    = 3'd4;
`ifdef CFG_CRC_EN
    localparam logic [2:0] S_CRC_FETCH = 3'd5;
`endif

    logic [2:0]        r_state;
    logic [WORD_W-1:0] r_word;
    logic [WBIT_W-1:0] r_wbit;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DIV_W-1:0]  r_div;
    logic              r_cfg_in;

    logic [WBIT_W-1:0] w_wbit_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_div_last;
    logic              w_chain_done;
    logic              w_unused;

    assign w_wbit_nxt   = r_wbit + 1'b1;
    assign w_cnt_nxt    = r_bit_cnt + 1'b1;
    assign w_div_last   = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_chain_done = (w_cnt_nxt == CNT_W'(CONFIG_WIDTH));
    // Chain tail is not read back; only kept on the port for integration.
    assign w_unused     = i_config_out;

`ifdef CFG_CRC_EN
    logic [15:0] r_crc;
    logic        r_crc_err;
    logic        w_crc_fb;
    logic [15:0] w_crc_nxt;

    assign w_crc_fb  = r_crc[15] ^ r_cfg_in;
    assign w_crc_nxt = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
    assign o_crc_err = r_crc_err;
`else
    assign o_crc_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_word    <= '0;
            r_wbit    <= '0;
            r_bit_cnt <= '0;
            r_div     <= '0;
            r_cfg_in  <= 1'b0;
`ifdef CFG_CRC_EN
            r_crc     <= 16'hFFFF;
            r_crc_err <= 1'b0;
`endif
        end else if (i_abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state   <= S_FETCH;
                        r_bit_cnt <= '0;
                        r_wbit    <= '0;
                        r_div     <= '0;
`ifdef CFG_CRC_EN
                        r_crc     <= 16'hFFFF;
                        r_crc_err <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    if (i_word_valid) begin
                        r_word   <= i_word_data;
                        r_cfg_in <= i_word_data[0];
                        r_wbit   <= '0;
                        r_div    <= '0;
                        r_state  <= S_SHIFT_LO;
                    end
                end
                S_SHIFT_LO: begin
                    if (w_div_last) begin
                        r_div   <= '0;
                        r_state <= S_SHIFT_HI;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_SHIFT_HI: begin
                    if (w_div_last) begin
                        r_div     <= '0;
                        r_bit_cnt <= w_cnt_nxt;
`ifdef CFG_CRC_EN
                        r_crc     <= w_crc_nxt;
`endif
                        // Remaining upper bits of the final word are dropped here.
                        if (w_chain_done) begin
`ifdef CFG_CRC_EN
                            r_state <= S_CRC_FETCH;
`else
                            r_state <= S_FINISH;
`endif
                        end else if (r_wbit == WBIT_W'(WORD_W - 1)) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_wbit   <= w_wbit_nxt;
                            r_cfg_in <= r_word[w_wbit_nxt];
                            r_state  <= S_SHIFT_LO;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
`ifdef CFG_CRC_EN
                S_CRC_FETCH: begin
                    if (i_word_valid) begin
                        if (i_word_data[15:0] != r_crc) begin
                            r_crc_err <= 1'b1;
                        end
                        r_state <= S_FINISH;
                    end
                end
`endif
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CFG_CRC_EN
    assign o_word_ready = (r_state == S_FETCH) || (r_state == S_CRC_FETCH);
`else
    assign o_word_ready = (r_state == S_FETCH);
`endif
    assign o_config_en  = (r_state == S_FETCH) || (r_state == S_SHIFT_LO) ||
                          (r_state == S_SHIFT_HI);
    assign o_config_clk = (r_state == S_SHIFT_HI);
    assign o_config_in  = r_cfg_in;
    assign o_busy       = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign o_done       = (r_state == S_FINISH);

endmodule

`default_nettype wire

// File: tb/tb_config_loader.sv
// ============================================================================
// Module   : tb_config_loader
// Purpose  : Directed self-checking bench for config_loader (40-bit chain).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_config_loader;

    localparam int CW = 40;
    localparam int WW = 32;
    localparam int CD = 1;
`ifdef CFG_CRC_EN
    localparam int CRC_EXTRA = 1;
`else
    localparam int CRC_EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [WW-1:0] i_word_data = '0;
    logic          i_word_valid = 1'b0;
    logic          i_config_out = 1'b0;
    logic          o_word_ready, o_config_in, o_config_clk, o_config_en;
    logic          o_busy, o_done, o_crc_err;

    int vectors = 0;
    int miscompares = 0;

    logic [CW-1:0] model = '0;
    int            edges = 0;

    always #5 clk = ~clk;

    config_loader #(.CONFIG_WIDTH(CW), .WORD_W(WW), .CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_word_data(i_word_data), .i_word_valid(i_word_valid),
        .o_word_ready(o_word_ready), .o_config_in(o_config_in),
        .o_config_clk(o_config_clk), .o_config_en(o_config_en),
        .i_config_out(i_config_out), .o_busy(o_busy), .o_done(o_done),
        .o_crc_err(o_crc_err)
    );

    // Fabric model: first shifted bit ends up at model[0]
    always @(posedge o_config_clk) begin
        model <= {o_config_in, model[CW-1:1]};
        edges <= edges + 1;
    end

    function automatic logic [15:0] crc_of(input logic [CW-1:0] b);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < CW; i++) begin
            fb = c[15] ^ b[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Runs one load; cycle 1 is the first cycle after the start edge.
    task automatic do_load(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [15:0] crcw, input int stall,
                           input int abort_at, input int restart_at,
                           output int done_cyc, output int ndone, output int nedges,
                           output logic en_done, output logic en_prev,
                           output int stall_bad, output int nwords,
                           output logic crc_done, output int abort_bad);
        int   base, cyc, stall_cnt, abort_cyc;
        logic offered, prev_en;
        base = edges; done_cyc = -1; ndone = 0; stall_bad = 0; nwords = 0;
        abort_bad = 0; stall_cnt = 0; abort_cyc = -1; offered = 1'b0;
        prev_en = 1'b0; en_done = 1'bx; en_prev = 1'bx; crc_done = 1'bx;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        cyc = 1;
        while (cyc < 400) begin
            if (offered) nwords++;
            if (o_done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; en_done = o_config_en;
                    en_prev = prev_en; crc_done = o_crc_err;
                end
            end
            if (abort_cyc >= 0 && cyc == abort_cyc + 1 &&
                (o_config_en | o_busy | o_word_ready | o_config_clk)) abort_bad++;
            i_abort = 1'b0;
            i_start = (cyc == restart_at);
            offered = 1'b0;
            i_word_valid = 1'b0;
            if (abort_at > 0 && abort_cyc < 0 && (edges - base) == abort_at) begin
                i_abort = 1'b1;
                abort_cyc = cyc;
            end else if (o_word_ready) begin
                if (nwords == 1 && stall_cnt < stall) begin
                    stall_cnt++;
                    if (o_config_clk !== 1'b0 || o_config_en !== 1'b1) stall_bad++;
                end else begin
                    i_word_valid = 1'b1;
                    i_word_data  = (nwords == 0) ? w0 : (nwords == 1) ? w1 : {16'h0, crcw};
                    offered      = 1'b1;
                end
            end
            prev_en = o_config_en;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            if (abort_cyc >= 0 && cyc >= abort_cyc + 6) break;
            @(posedge clk); #1;
            cyc++;
        end
        i_start = 1'b0; i_abort = 1'b0; i_word_valid = 1'b0;
        nedges = edges - base;
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        i_start = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        outs = {o_word_ready, o_config_in, o_config_clk, o_config_en, o_busy, o_done, o_crc_err};
        vectors++;
        if (outs !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, expected %b", outs, 7'b0);
        end
        @(negedge clk);
        i_start = 1'b0;
        rst_n   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        outs = {o_word_ready, o_config_in, o_config_clk, o_config_en, o_busy, o_done, o_crc_err};
        vectors++;
        if (outs !== 7'b0) begin
            miscompares++;
            $display("FAIL idle_after_release: got %b, expected %b", outs, 7'b0);
        end
    endtask

    task automatic test_load();
        int dc, nd, ne, sb, nw, ab;
        logic ed, ep, cd;
        do_load(32'hA5A5_0F0F, 32'h0000_00C3, crc_of(40'hC3_A5A5_0F0F), 0, 0, 0,
                dc, nd, ne, ed, ep, sb, nw, cd, ab);
        vectors++;
        if (model !== 40'hC3_A5A5_0F0F) begin
            miscompares++;
            $display("FAIL load_model: got %h, expected %h", model, 40'hC3_A5A5_0F0F);
        end
        vectors++;
        if (dc !== 83 + CRC_EXTRA) begin
            miscompares++;
            $display("FAIL load_done_cycle: got %0d, expected %0d", dc, 83 + CRC_EXTRA);
        end
        vectors++;
        if (nd !== 1 || ne !== CW) begin
            miscompares++;
            $display("FAIL load_counts: got done=%0d edges=%0d, expected done=1 edges=%0d", nd, ne, CW);
        end
        vectors++;
        if (ed !== 1'b0 || (CRC_EXTRA == 0 && ep !== 1'b1)) begin
            miscompares++;
            $display("FAIL load_en_fall: got en=%b prev=%b, expected en=0 prev=1", ed, ep);
        end
        vectors++;
        if (o_busy !== 1'b0 || o_config_en !== 1'b0) begin
            miscompares++;
            $display("FAIL load_idle_after: got busy=%b en=%b, expected 0 0", o_busy, o_config_en);
        end
    endtask

    task automatic test_stall();
        int dc, nd, ne, sb, nw, ab;
        logic ed, ep, cd;
        do_load(32'hA5A5_0F0F, 32'h0000_00C3, crc_of(40'hC3_A5A5_0F0F), 10, 0, 0,
                dc, nd, ne, ed, ep, sb, nw, cd, ab);
        vectors++;
        if (sb !== 0) begin
            miscompares++;
            $display("FAIL stall_outputs: got %0d bad cycles, expected 0", sb);
        end
        vectors++;
        if (model !== 40'hC3_A5A5_0F0F) begin
            miscompares++;
            $display("FAIL stall_model: got %h, expected %h", model, 40'hC3_A5A5_0F0F);
        end
        vectors++;
        if (dc !== 93 + CRC_EXTRA) begin
            miscompares++;
            $display("FAIL stall_done_cycle: got %0d, expected %0d", dc, 93 + CRC_EXTRA);
        end
    endtask

    task automatic test_abort();
        int dc, nd, ne, sb, nw, ab;
        logic ed, ep, cd;
        do_load(32'hA5A5_0F0F, 32'h0000_00C3, 16'h0, 0, 20, 0,
                dc, nd, ne, ed, ep, sb, nw, cd, ab);
        vectors++;
        if (ab !== 0 || nd !== 0) begin
            miscompares++;
            $display("FAIL abort_outputs: got bad=%0d done=%0d, expected 0 0", ab, nd);
        end
        vectors++;
        if (ne !== 20) begin
            miscompares++;
            $display("FAIL abort_edges: got %0d, expected 20", ne);
        end
        // Upper bits of the last word must not reach the chain.
        do_load(32'h1234_5678, 32'hFFFF_FF5A, crc_of(40'h5A_1234_5678), 0, 0, 0,
                dc, nd, ne, ed, ep, sb, nw, cd, ab);
        vectors++;
        if (model !== 40'h5A_1234_5678 || nd !== 1) begin
            miscompares++;
            $display("FAIL abort_reload: got %h done=%0d, expected %h done=1", model, nd, 40'h5A_1234_5678);
        end
    endtask

    task automatic test_restart_ignored();
        int dc, nd, ne, sb, nw, ab;
        logic ed, ep, cd;
        do_load(32'hDEAD_BEEF, 32'h0000_0081, crc_of(40'h81_DEAD_BEEF), 0, 0, 30,
                dc, nd, ne, ed, ep, sb, nw, cd, ab);
        vectors++;
        if (ne !== CW || nd !== 1) begin
            miscompares++;
            $display("FAIL restart_counts: got edges=%0d done=%0d, expected %0d 1", ne, nd, CW);
        end
        vectors++;
        if (model !== 40'h81_DEAD_BEEF || dc !== 83 + CRC_EXTRA) begin
            miscompares++;
            $display("FAIL restart_result: got %h at %0d, expected %h at %0d", model, dc, 40'h81_DEAD_BEEF, 83 + CRC_EXTRA);
        end
    endtask

    task automatic test_crc();
        int dc, nd, ne, sb, nw, ab;
        logic ed, ep, cd;
        logic [15:0] good;
        good = crc_of(40'hC3_A5A5_0F0F);
        do_load(32'hA5A5_0F0F, 32'h0000_00C3, good, 0, 0, 0,
                dc, nd, ne, ed, ep, sb, nw, cd, ab);
`ifdef CFG_CRC_EN
        vectors++;
        if (cd !== 1'b0 || nw !== 3) begin
            miscompares++;
            $display("FAIL crc_good: got err=%b words=%0d, expected 0 3", cd, nw);
        end
        do_load(32'hA5A5_0F0F, 32'h0000_00C3, good ^ 16'h0001, 0, 0, 0,
                dc, nd, ne, ed, ep, sb, nw, cd, ab);
        vectors++;
        if (cd !== 1'b1 || nd !== 1) begin
            miscompares++;
            $display("FAIL crc_bad: got err=%b done=%0d, expected 1 1", cd, nd);
        end
        vectors++;
        if (o_crc_err !== 1'b1) begin
            miscompares++;
            $display("FAIL crc_sticky: got %b, expected 1", o_crc_err);
        end
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        vectors++;
        if (o_crc_err !== 1'b0) begin
            miscompares++;
            $display("FAIL crc_clear: got %b, expected 0", o_crc_err);
        end
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
`else
        vectors++;
        if (cd !== 1'b0 || nw !== 2) begin
            miscompares++;
            $display("FAIL nocrc_words: got err=%b words=%0d, expected 0 2", cd, nw);
        end
`endif
    endtask

    task automatic test_async_reset();
        logic [6:0] outs;
        int         nd;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_word_valid = 1'b1;
        i_word_data  = 32'hFFFF_FFFF;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        outs = {o_word_ready, o_config_in, o_config_clk, o_config_en, o_busy, o_done, o_crc_err};
        vectors++;
        if (outs !== 7'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %b, expected %b", outs, 7'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (o_done || o_busy) nd++;
        end
        i_word_valid = 1'b0;
        vectors++;
        if (nd !== 0) begin
            miscompares++;
            $display("FAIL async_no_done: got %0d active cycles, expected 0", nd);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_abort();
        test_restart_ignored();
        test_crc();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
